// File: rtl/jedro_1_data_ram.sv
// Single-port data memory responding on the jedro_1 data interface.
// Zero-cycle grant, byte-enabled writes, fixed-latency in-order responses.
module jedro_1_data_ram #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           MEM_WORDS  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int unsigned           LATENCY    = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    data_req_i,
   output logic                    data_gnt_o,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic                    data_err_o,
   input  logic                    stall_i
);

   localparam int unsigned         IDX_W     = $clog2(MEM_WORDS);
   localparam int unsigned         NBYTES    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_WORDS * 4);

   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      idx;
   logic                  addr_err;
   logic                  accept;
   logic [DATA_WIDTH-1:0] load_rdata;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic [LATENCY-1:0]    pipe_valid;
   logic [LATENCY-1:0]    pipe_err;
   logic [DATA_WIDTH-1:0] pipe_rdata [LATENCY];

   always_comb begin
      data_gnt_o = data_req_i & ~stall_i & ~rst_i;
      accept     = data_req_i & data_gnt_o;
      offset     = data_addr_i - BASE_ADDR;
      // Offset wraps below BASE_ADDR, so a single unsigned compare covers both sides.
      addr_err   = ({1'b0, offset} >= MEM_BYTES) || (data_addr_i[1:0] != 2'b00);
      idx        = offset[IDX_W+1:2];
      load_rdata = '0;
      if (accept && !data_we_i && !addr_err) begin
         load_rdata = mem[idx];
      end
   end

   // Memory contents are intentionally left out of reset.
   always_ff @(posedge clk_i) begin
      if (accept && data_we_i && !addr_err) begin
         for (int n = 0; n < NBYTES; n++) begin
            if (data_be_i[n]) begin
               mem[idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_rdata[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= accept;
         pipe_err[0]   <= accept & addr_err;
         pipe_rdata[0] <= load_rdata;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_rdata[i] <= pipe_rdata[i-1];
         end
      end
   end

   assign data_rvalid_o = pipe_valid[LATENCY-1];
   assign data_err_o    = pipe_err[LATENCY-1];
   assign data_rdata_o  = pipe_rdata[LATENCY-1];

endmodule
